// File: rtl/vga_pkg.sv
// Shared types and default timing for the VGA raster generator.
package vga_pkg;

  typedef logic [7:0] rgb332_t;

  // 640x480@60 industry timing, in pixel ticks (horizontal) and lines (vertical)
  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FP_DEF      = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BP_DEF      = 48;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FP_DEF      = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BP_DEF      = 33;

  localparam rgb332_t BLACK = 8'h00;
  localparam rgb332_t GREEN = 8'h1C;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with visible and sync-window decode.
// Segment order along the axis is visible, front porch, sync, back porch.
module vga_axis_counter #(
  parameter  int VIS   = 640,
  parameter  int FP    = 16,
  parameter  int SYNC  = 96,
  parameter  int BP    = 48,
  localparam int TOTAL = VIS + FP + SYNC + BP,
  localparam int CW    = $clog2(TOTAL)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          tick_i,
  output logic [CW-1:0] count_o,
  output logic          wrap_o,
  output logic          visible_o,
  output logic          sync_n_o
);
  localparam logic [CW-1:0] LAST     = CW'(TOTAL - 1);
  localparam logic [CW-1:0] VIS_END  = CW'(VIS);
  localparam logic [CW-1:0] SYNC_BEG = CW'(VIS + FP);
  localparam logic [CW-1:0] SYNC_END = CW'(VIS + FP + SYNC);

  logic [CW-1:0] count_q, count_d;

  assign wrap_o    = tick_i && (count_q == LAST);
  assign visible_o = (count_q < VIS_END);
  assign sync_n_o  = !((count_q >= SYNC_BEG) && (count_q < SYNC_END));
  assign count_o   = count_q;

  // Next position: clear dominates, otherwise advance on tick and wrap at the last position
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (tick_i) begin
      count_d = wrap_o ? '0 : count_q + CW'(1);
    end
  end

  // Position register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator running at HCLK/2.
// Stage 0 (tick edge): issue a frame-buffer read for the current position and advance.
// Stage 1 (next tick edge): present sync/colour for that position; read data has
// had one HCLK to arrive, so RGB lines up with HSYNC/VSYNC one pixel tick late.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FP      = H_FP_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BP      = H_BP_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FP      = V_FP_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BP      = V_BP_DEF
) (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       en,
  output logic [9:0] pix_x,
  output logic [8:0] pix_y,
  output logic       pix_req,
  input  rgb332_t    pix_data,
  output logic       HSYNC,
  output logic       VSYNC,
  output rgb332_t    RGB,
  output logic       vblank,
  output logic       frame_start
);
  localparam int H_CW = $clog2(H_VISIBLE + H_FP + H_SYNC + H_BP);
  localparam int V_CW = $clog2(V_VISIBLE + V_FP + V_SYNC + V_BP);

  if ((H_VISIBLE > 1024) || (V_VISIBLE > 512)) begin : g_size_check
    $error("vga_timing_gen: visible area exceeds the 1024x512 frame-buffer address space");
  end

  logic            adv;
  logic [H_CW-1:0] h_count;
  logic [V_CW-1:0] v_count;
  logic            h_wrap, h_vis, h_sync_n;
  logic            v_wrap_unused, v_vis, v_sync_n;

  logic       tick_q, tick_d;
  logic       pix_req_q, pix_req_d;
  logic [9:0] pix_x_q, pix_x_d;
  logic [8:0] pix_y_q, pix_y_d;
  // stage-0 decode carried to stage 1
  logic       hs_p_q, hs_p_d, vs_p_q, vs_p_d;
  logic       vis_p_q, vis_p_d, vbl_p_q, vbl_p_d, org_p_q, org_p_d;
  // stage-1 outputs
  logic       hsync_q, hsync_d, vsync_q, vsync_d;
  rgb332_t    rgb_q, rgb_d;
  logic       vblank_q, vblank_d, fs_q, fs_d;

  assign adv = en && tick_q;

  vga_axis_counter #(.VIS(H_VISIBLE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)) u_h (
    .clk_i(HCLK), .rst_ni(HRESETn), .clr_i(!en), .tick_i(adv),
    .count_o(h_count), .wrap_o(h_wrap), .visible_o(h_vis), .sync_n_o(h_sync_n)
  );

  vga_axis_counter #(.VIS(V_VISIBLE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)) u_v (
    .clk_i(HCLK), .rst_ni(HRESETn), .clr_i(!en), .tick_i(h_wrap),
    .count_o(v_count), .wrap_o(v_wrap_unused), .visible_o(v_vis), .sync_n_o(v_sync_n)
  );

  // Pipeline next-state: idle values while disabled, otherwise both stages move on a tick
  always_comb begin
    tick_d    = 1'b0;
    pix_req_d = 1'b0;
    pix_x_d   = pix_x_q;
    pix_y_d   = pix_y_q;
    hs_p_d    = hs_p_q;
    vs_p_d    = vs_p_q;
    vis_p_d   = vis_p_q;
    vbl_p_d   = vbl_p_q;
    org_p_d   = org_p_q;
    hsync_d   = hsync_q;
    vsync_d   = vsync_q;
    rgb_d     = rgb_q;
    vblank_d  = vblank_q;
    fs_d      = 1'b0;
    if (!en) begin
      hs_p_d   = 1'b1;
      vs_p_d   = 1'b1;
      vis_p_d  = 1'b0;
      vbl_p_d  = 1'b0;
      org_p_d  = 1'b0;
      hsync_d  = 1'b1;
      vsync_d  = 1'b1;
      rgb_d    = BLACK;
      vblank_d = 1'b0;
    end else begin
      tick_d = !tick_q;
      if (tick_q) begin
        pix_req_d = h_vis && v_vis;
        if (h_vis && v_vis) begin
          pix_x_d = 10'(h_count);
          pix_y_d = 9'(v_count);
        end
        hs_p_d   = h_sync_n;
        vs_p_d   = v_sync_n;
        vis_p_d  = h_vis && v_vis;
        vbl_p_d  = !v_vis;
        org_p_d  = (h_count == '0) && (v_count == '0);
        hsync_d  = hs_p_q;
        vsync_d  = vs_p_q;
        rgb_d    = vis_p_q ? pix_data : BLACK;
        vblank_d = vbl_p_q;
        fs_d     = org_p_q;
      end
    end
  end

  // Pipeline registers
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      tick_q    <= 1'b0;
      pix_req_q <= 1'b0;
      pix_x_q   <= '0;
      pix_y_q   <= '0;
      hs_p_q    <= 1'b1;
      vs_p_q    <= 1'b1;
      vis_p_q   <= 1'b0;
      vbl_p_q   <= 1'b0;
      org_p_q   <= 1'b0;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
      rgb_q     <= BLACK;
      vblank_q  <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      tick_q    <= tick_d;
      pix_req_q <= pix_req_d;
      pix_x_q   <= pix_x_d;
      pix_y_q   <= pix_y_d;
      hs_p_q    <= hs_p_d;
      vs_p_q    <= vs_p_d;
      vis_p_q   <= vis_p_d;
      vbl_p_q   <= vbl_p_d;
      org_p_q   <= org_p_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      rgb_q     <= rgb_d;
      vblank_q  <= vblank_d;
      fs_q      <= fs_d;
    end
  end

  assign pix_req     = pix_req_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign HSYNC       = hsync_q;
  assign VSYNC       = vsync_q;
  assign RGB         = rgb_q;
  assign vblank      = vblank_q;
  assign frame_start = fs_q;

endmodule
